// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving a shared 1-bit ALU, LSB first, with carry/borrow
// chaining between bit slices for add/subtract.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op_mode,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] y,
  output logic             carry_out,
  output logic [1:0]       alu_mode,
  output logic [1:0]       alu_opcode,
  output logic             alu_ain,
  output logic             alu_bin,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam int CW = $clog2(WIDTH);

  // state  | meaning
  // IDLE   | ready, waiting for start
  // RUN    | one bit slice per cycle through the ALU
  // DONE   | result published, done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, code_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, y_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, err_q;
  logic             accept, reject, last, chain, s, c_d;

  assign accept = (state_q == S_IDLE) && start && (op_mode != 2'b11);
  assign reject = (state_q == S_IDLE) && start && (op_mode == 2'b11);
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign chain  = (mode_q == 2'b01) && !code_q[1];

  // c_q is carry for ADD and borrow for SUB; both use s = r ^ c
  always_comb begin
    s   = alu_result;
    c_d = 1'b0;
    if (chain) begin
      s = alu_result ^ c_q;
      if (code_q[0]) c_d = alu_cout | (~alu_result & c_q);
      else           c_d = alu_cout | (alu_result & c_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last)   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready      = (state_q == S_IDLE);
    done       = (state_q == S_DONE);
    alu_mode   = 2'b00;
    alu_opcode = 2'b00;
    alu_ain    = 1'b0;
    alu_bin    = 1'b0;
    if (state_q == S_RUN) begin
      alu_mode   = mode_q;
      alu_opcode = code_q;
      alu_ain    = a_sh_q[0];
      alu_bin    = b_sh_q[0];
    end
  end

  // y/carry_out load on the final RUN edge so they are valid alongside done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= '0;
      code_q <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      y_q    <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        mode_q <= op_mode;
        code_q <= op_code;
        a_sh_q <= a;
        b_sh_q <= b;
        res_q  <= '0;
        cnt_q  <= '0;
        c_q    <= 1'b0;
      end else if (state_q == S_RUN) begin
        a_sh_q <= a_sh_q >> 1;
        b_sh_q <= b_sh_q >> 1;
        res_q  <= {s, res_q[WIDTH-1:1]};
        c_q    <= c_d;
        if (last) begin
          y_q    <= {s, res_q[WIDTH-1:1]};
          cout_q <= c_d;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign err       = err_q;
  assign y         = y_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural 1-bit ALU attached.
module tb_alu_serial_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] op_mode, op_code;
  logic [7:0] a, b;
  logic       ready, done, err;
  logic [7:0] y;
  logic       carry_out;
  logic [1:0] alu_mode, alu_opcode;
  logic       alu_ain, alu_bin, alu_result, alu_cout;

  int passed = 0;
  int total  = 0;

  alu_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_mode(op_mode), .op_code(op_code),
    .a(a), .b(b), .ready(ready), .done(done), .err(err), .y(y), .carry_out(carry_out),
    .alu_mode(alu_mode), .alu_opcode(alu_opcode), .alu_ain(alu_ain), .alu_bin(alu_bin),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // 1-bit ALU: mode 01 is half-add/half-sub; other modes are logic ops, no carry
  always_comb begin
    alu_result = 1'b0;
    alu_cout   = 1'b0;
    if (alu_mode == 2'b01) begin
      alu_result = alu_ain ^ alu_bin;
      alu_cout   = alu_opcode[0] ? (~alu_ain & alu_bin) : (alu_ain & alu_bin);
    end else begin
      case (alu_opcode)
        2'b00:   alu_result = alu_ain & alu_bin;
        2'b01:   alu_result = alu_ain | alu_bin;
        2'b10:   alu_result = alu_ain ^ alu_bin;
        default: alu_result = ~alu_ain;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [1:0] m, input logic [1:0] c,
                       input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    start = 1'b1; op_mode = m; op_code = c; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the start edge; returns negedges until done.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input logic [1:0] c,
                        input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] ey, input logic ec);
    int lat;
    issue(m, c, va, vb);
    wait_done(lat);
    check({tag, "_lat"}, lat, 9);
    check({tag, "_y"}, y, ey);
    check({tag, "_c"}, carry_out, ec);
    @(negedge clk);
    check({tag, "_ready"}, {ready, done}, 2'b10);
  endtask

  initial begin
    int lat;
    int seen;
    reset_n = 1'b0; start = 1'b0; op_mode = 2'b00; op_code = 2'b00; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ctl", {ready, done, err}, 3'b100);
    check("rst_y", {y, carry_out}, 9'h000);
    check("rst_alu", {alu_mode, alu_opcode, alu_ain, alu_bin}, 6'b0);
    reset_n = 1'b1;

    run_op("add_ff_01", 2'b01, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1);
    run_op("add_3a_47", 2'b01, 2'b00, 8'h3A, 8'h47, 8'h81, 1'b0);
    run_op("sub_10_01", 2'b01, 2'b01, 8'h10, 8'h01, 8'h0F, 1'b0);
    run_op("sub_00_01", 2'b01, 2'b01, 8'h00, 8'h01, 8'hFF, 1'b1);

    // pass-through AND: operand bits presented LSB first
    issue(2'b10, 2'b00, 8'hA5, 8'h3C);
    begin
      logic [7:0] exp_ain = 8'b1010_0101;  // bit k = RUN cycle k+1
      logic [7:0] exp_bin = 8'b0011_1100;
      for (int k = 0; k < 8; k++) begin
        check($sformatf("pass_ain_%0d", k), alu_ain, exp_ain[k]);
        check($sformatf("pass_bin_%0d", k), alu_bin, exp_bin[k]);
        check($sformatf("pass_mode_%0d", k), {alu_mode, alu_opcode}, 4'b1000);
        @(negedge clk);
      end
    end
    check("pass_done", done, 1'b1);
    check("pass_y", y, 8'h24);
    check("pass_c", carry_out, 1'b0);
    check("pass_alu_idle", {alu_mode, alu_opcode, alu_ain, alu_bin}, 6'b0);

    // rejected request
    issue(2'b11, 2'b00, 8'h11, 8'h22);
    check("err_pulse", {err, ready, done}, 3'b110);
    @(negedge clk);
    check("err_clear", {err, ready}, 2'b01);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("err_no_done", seen, 0);
    check("err_y_held", {y, carry_out}, 9'h048);

    // start during RUN is ignored
    @(negedge clk);
    start = 1'b1; op_mode = 2'b01; op_code = 2'b00; a = 8'h3A; b = 8'h47;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op_mode = 2'b01; op_code = 2'b01; a = 8'h00; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", ready, 1'b0);
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_lat", lat, 9);
    check("ign_y", {y, carry_out}, 9'h102);
    @(negedge clk);
    check("ign_idle", {ready, done}, 2'b10);

    // reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op_mode = 2'b01; op_code = 2'b00; a = 8'hFF; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_ctl", {ready, done, err}, 3'b100);
    check("abort_y", {y, carry_out}, 9'h000);
    check("abort_alu", {alu_mode, alu_opcode, alu_ain, alu_bin}, 6'b0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || err) seen++;
    end
    check("abort_no_done", seen, 0);
    run_op("post_rst_sub", 2'b01, 2'b01, 8'h00, 8'h01, 8'hFF, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
